axilite_m: RTL and testbench

- AXI-Lite initiator (master) for the team's AXI-Lite slave memory blocks.
- Accepts one single-beat read or write command on a simple valid/ready command port and drives the five AXI-Lite channels.
- Returns read data and response on a valid/ready response port.
- One transaction in flight; watchdog converts a hung slave into an error response.

---
 rtl/axilite_m.sv | 144 ++++++++++++++
 tb/tb_axilite_m.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_m.sv
// AXI-Lite initiator: one single-beat read/write in flight,
// command/response ports with valid/ready, watchdog on hung slaves.
module axilite_m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP
  } state_t;

  localparam bit        WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;
  logic aw_done, w_done;
  logic aw_hs, w_hs;
  logic wd_hit, tmo;
  logic [15:0] wd_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0] resp_q;
  logic to_q;

  assign cmd_ready     = (state == IDLE);
  assign m_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_REQ);
  assign m_axi_rready  = (state == RD_DATA);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign rsp_valid     = (state == RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = to_q;

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign wd_hit = WD_EN && (wd_cnt == WD_LIM);

  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    case (state)
      IDLE:
        if (cmd_valid) state_n = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
        else if (wd_hit) begin state_n = RSP; tmo = 1'b1; end
      WR_RESP:
        if (m_axi_bvalid) state_n = RSP;
        else if (wd_hit) begin state_n = RSP; tmo = 1'b1; end
      RD_REQ:
        if (m_axi_arready) state_n = RD_DATA;
        else if (wd_hit) begin state_n = RSP; tmo = 1'b1; end
      RD_DATA:
        if (m_axi_rvalid) state_n = RSP;
        else if (wd_hit) begin state_n = RSP; tmo = 1'b1; end
      RSP:
        if (rsp_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state   <= IDLE;
      wd_cnt  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state <= state_n;
      // counter restarts on every state change, so it times each state
      if (state_n != state) wd_cnt <= '0;
      else if (state != IDLE && state != RSP) wd_cnt <= wd_cnt + 16'd1;
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
        end
      end else if (state == WR_REQ) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end
      if (tmo) begin
        rdata_q <= '0;
        resp_q  <= 2'b10;
        to_q    <= 1'b1;
      end else if (state == WR_RESP && m_axi_bvalid) begin
        rdata_q <= '0;
        resp_q  <= m_axi_bresp;
        to_q    <= 1'b0;
      end else if (state == RD_DATA && m_axi_rvalid) begin
        rdata_q <= m_axi_rdata;
        resp_q  <= m_axi_rresp;
        to_q    <= 1'b0;
      end else if (state == RSP && rsp_ready) begin
        to_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axilite_m.sv
// Bench for axilite_m: table of transactions against a 128-word
// slave model, plus ordering, watchdog, back-pressure and reset cases.
module tb_axilite_m;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [1:0]  bresp, rresp;

  axilite_m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  // slave model
  logic [31:0] mem [128];
  int aw_dly = 0, w_dly = 0;
  bit ar_block = 0, b_hold = 0;
  int aw_cnt, w_cnt;
  logic got_aw, got_w;
  logic [31:0] s_addr, s_data;
  int n_aw = 0, n_w = 0, n_b = 0, r_aw = 0, r_w = 0, ar_hi = 0;
  logic aw_prev = 0, w_prev = 0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && !ar_block;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_aw <= 0; got_w <= 0; bvalid <= 0; bresp <= 0;
      rvalid <= 0; rdata <= 0; rresp <= 0;
      aw_cnt <= 0; w_cnt <= 0; s_addr <= 0; s_data <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin s_addr <= awaddr; got_aw <= 1; end
      if (wvalid && wready) begin s_data <= wdata; got_w <= 1; end
      if (got_aw && got_w && !bvalid && !b_hold) begin
        if (s_addr < 128) begin
          mem[s_addr[6:0]] <= s_data;
          bresp <= 2'b00;
        end else bresp <= 2'b11;
        bvalid <= 1; got_aw <= 0; got_w <= 0;
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1;
        if (araddr < 128) begin rdata <= mem[araddr[6:0]]; rresp <= 2'b00; end
        else begin rdata <= 0; rresp <= 2'b11; end
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  always @(posedge clk) begin
    aw_prev <= awvalid;
    w_prev  <= wvalid;
    if (awvalid && !aw_prev) r_aw <= r_aw + 1;
    if (wvalid && !w_prev) r_w <= r_w + 1;
    if (awvalid && awready) n_aw <= n_aw + 1;
    if (wvalid && wready) n_w <= n_w + 1;
    if (bvalid && bready) n_b <= n_b + 1;
    if (arvalid) ar_hi <= ar_hi + 1;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_to;
  } vec_t;

  vec_t sb[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int hold);
    int n;
    vec_t e;
    bit stable;
    sb.push_back(v);
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    e = sb.pop_front();
    if (!rsp_valid) begin
      chk("rsp_wait", 0, 1);
      rsp_ready = 1;
      return;
    end
    chk("rdata", rsp_rdata, e.exp_rdata);
    chk("resp", rsp_resp, e.exp_resp);
    chk("timeout", rsp_timeout, e.exp_to);
    if (hold > 0) begin
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        if (!rsp_valid || rsp_rdata !== e.exp_rdata || cmd_ready) stable = 0;
        @(negedge clk);
      end
      chk("hold_stable", stable, 1);
      rsp_ready = 1;
    end
    @(posedge clk); @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_after", cmd_ready, 1);
    chk("to_clear", rsp_timeout, 0);
  endtask

  vec_t vecs[9];
  vec_t v;
  int b_aw, b_w, b_b, b_raw, b_rw, b_ar;
  bit saw;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    vecs[0] = '{1, 5,   32'hDEADBEEF, 0,            2'b00, 0};
    vecs[1] = '{0, 5,   0,            32'hDEADBEEF, 2'b00, 0};
    vecs[2] = '{1, 200, 32'h0BADF00D, 0,            2'b11, 0};
    vecs[3] = '{0, 300, 0,            0,            2'b11, 0};
    vecs[4] = '{1, 127, 32'hA5A55A5A, 0,            2'b00, 0};
    vecs[5] = '{0, 127, 0,            32'hA5A55A5A, 2'b00, 0};
    vecs[6] = '{0, 128, 0,            0,            2'b11, 0};
    vecs[7] = '{1, 0,   32'h12345678, 0,            2'b00, 0};
    vecs[8] = '{0, 0,   0,            32'h12345678, 2'b00, 0};
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {awvalid, wvalid, bready, arvalid, rready,
                    rsp_valid, rsp_timeout, rsp_resp}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1;

    for (int i = 0; i < 9; i++) run(vecs[i], 0);

    // AW/W handshake ordering
    for (int k = 0; k < 3; k++) begin
      aw_dly = (k == 0) ? 3 : 0;
      w_dly  = (k == 1) ? 3 : 0;
      b_aw = n_aw; b_w = n_w; b_b = n_b; b_raw = r_aw; b_rw = r_w;
      v = '{1, 32'(20 + k), 32'hC0DE0000 + 32'(k), 0, 2'b00, 0};
      run(v, 0);
      chk("order_hs", {8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_b - b_b),
                       8'(r_aw - b_raw), 8'(r_w - b_rw)}, 40'h0101010101);
      aw_dly = 0; w_dly = 0;
      v = '{0, 32'(20 + k), 0, 32'hC0DE0000 + 32'(k), 2'b00, 0};
      run(v, 0);
    end

    // watchdog on a read address channel that never accepts
    ar_block = 1;
    b_ar = ar_hi;
    v = '{0, 5, 0, 0, 2'b10, 1};
    run(v, 0);
    chk("ar_cycles", ar_hi - b_ar, 16);
    ar_block = 0;
    v = '{0, 5, 0, 32'hDEADBEEF, 2'b00, 0};
    run(v, 0);

    // response back-pressure
    v = '{0, 127, 0, 32'hA5A55A5A, 2'b00, 0};
    run(v, 10);

    // asynchronous reset in the middle of WR_RESP
    b_hold = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 9; cmd_wdata = 32'h11112222;
    @(posedge clk); #1 cmd_valid = 0;
    for (int n = 0; n < 50 && !bready; n++) @(negedge clk);
    chk("wresp_reached", bready, 1);
    @(posedge clk); #2 rst_n = 0; #1;
    chk("arst_ctl", {awvalid, wvalid, bready, arvalid, rready,
                     rsp_valid, rsp_timeout, rsp_resp}, 0);
    chk("arst_rdata", rsp_rdata, 0);
    chk("arst_addr", awaddr, 0);
    b_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    saw = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) saw = 1; end
    chk("no_stale_rsp", saw, 0);
    v = '{1, 9, 32'h33334444, 0, 2'b00, 0};
    run(v, 0);
    v = '{0, 9, 0, 32'h33334444, 2'b00, 0};
    run(v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
